// File: rtl/sram_ahb_slave_core_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the SRAM
// slave front end (slave side).
interface sram_ahb_slave_core_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/sram_ahb_slave_core.sv
// AHB-Lite front end for a 1-cycle synchronous SRAM: one SRAM action per cycle,
// a one-entry write buffer so reads never stall, and forwarding from that buffer.
module sram_ahb_slave_core #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0,
    parameter logic [31:0] NUM_BYTES    = 32'd24
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    sram_ahb_slave_core_if.slave        ahb,
    output logic [31:0]                 addr,
    output logic [1:0]                  size,
    output logic [31:0]                 ram_wData,
    output logic                        wen,
    output logic                        ren,
    input  logic [31:0]                 rData,
    output logic [31:0]                 latched_addr,
    output logic [31:0]                 latched_data,
    output logic [1:0]                  latched_size,
    output logic                        latched_flag
);
    typedef enum logic [1:0] {ERR_NONE, ERR_FIRST, ERR_SECOND} err_state_t;
    err_state_t err_state, err_next;

    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic        a_write;
    logic        a_active;

    logic [31:0] offset;
    logic        in_range, selected, act_now, bad_now;
    logic        rd_addr_phase, wr_data_phase, rd_data_phase;
    logic        buf_load, buf_clear;
    logic [3:0]  lane_mask;
    logic [31:0] merged;
    logic        unused_hsize;

    assign unused_hsize = &{1'b0, ahb.HSIZE[2]};

    // Addresses below the base wrap to large offsets, so one compare covers both bounds.
    assign offset        = ahb.HADDR - BASE_ADDRESS;
    assign in_range      = offset < NUM_BYTES;
    assign selected      = ahb.HSEL && ahb.HTRANS[1] && !HRESET && (err_state != ERR_FIRST);
    assign act_now       = selected && in_range;
    assign bad_now       = selected && !in_range;
    assign rd_addr_phase = act_now && !ahb.HWRITE;
    assign wr_data_phase = a_active && a_write && !HRESET;
    assign rd_data_phase = a_active && !a_write && !HRESET;

    always_comb begin
        err_next      = err_state;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = 1'b0;
        case (err_state)
            ERR_NONE: begin
                if (bad_now) err_next = ERR_FIRST;
            end
            ERR_FIRST: begin
                err_next      = ERR_SECOND;
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = 1'b1;
            end
            ERR_SECOND: begin
                ahb.HRESP = 1'b1;
                err_next  = bad_now ? ERR_FIRST : ERR_NONE;
            end
            default: err_next = ERR_NONE;
        endcase
    end

    // A read address phase always wins; a coincident write data phase is parked
    // in the buffer, which has always drained by then (a read precedes every load).
    always_comb begin
        wen       = 1'b0;
        ren       = 1'b0;
        addr      = '0;
        size      = '0;
        ram_wData = '0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (rd_addr_phase) begin
            ren      = 1'b1;
            addr     = offset;
            size     = ahb.HSIZE[1:0];
            buf_load = wr_data_phase;
        end else if (wr_data_phase) begin
            wen = 1'b1;
            if (latched_flag) begin
                addr      = latched_addr - BASE_ADDRESS;
                size      = latched_size;
                ram_wData = latched_data;
                buf_load  = 1'b1;
            end else begin
                addr      = a_addr - BASE_ADDRESS;
                size      = a_size;
                ram_wData = ahb.HWDATA;
            end
        end else if (latched_flag && !HRESET) begin
            wen       = 1'b1;
            addr      = latched_addr - BASE_ADDRESS;
            size      = latched_size;
            ram_wData = latched_data;
            buf_clear = 1'b1;
        end
    end

    always_comb begin
        case (latched_size)
            2'd0:    lane_mask = 4'b0001 << latched_addr[1:0];
            2'd1:    lane_mask = latched_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        merged = rData;
        if (latched_flag && (latched_addr[31:2] == a_addr[31:2])) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_mask[i]) merged[8*i +: 8] = latched_data[8*i +: 8];
            end
        end
        ahb.HRDATA = rd_data_phase ? merged : '0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_state    <= ERR_NONE;
            a_addr       <= '0;
            a_size       <= '0;
            a_write      <= 1'b0;
            a_active     <= 1'b0;
            latched_addr <= '0;
            latched_data <= '0;
            latched_size <= '0;
            latched_flag <= 1'b0;
        end else begin
            err_state <= err_next;
            a_addr    <= ahb.HADDR;
            a_size    <= ahb.HSIZE[1:0];
            a_write   <= ahb.HWRITE;
            a_active  <= act_now;
            if (buf_load) begin
                latched_addr <= a_addr;
                latched_data <= ahb.HWDATA;
                latched_size <= a_size;
                latched_flag <= 1'b1;
            end else if (buf_clear) begin
                latched_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_ahb_slave_core.sv
// Self-checking bench: vector table, directed buffer/forwarding/error/reset
// sequences, then random traffic checked against a flat architectural memory.
module tb_sram_ahb_slave_core;
    localparam int unsigned MEM = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_ahb_slave_core_if ahb ();
    logic [31:0] addr, ram_wData, rData, latched_addr, latched_data;
    logic [1:0]  size, latched_size;
    logic        wen, ren, latched_flag;

    sram_ahb_slave_core #(.BASE_ADDRESS(32'h0), .NUM_BYTES(32'd24)) dut (
        .HCLK(clk), .HRESET(rst), .ahb(ahb),
        .addr(addr), .size(size), .ram_wData(ram_wData), .wen(wen), .ren(ren),
        .rData(rData), .latched_addr(latched_addr), .latched_data(latched_data),
        .latched_size(latched_size), .latched_flag(latched_flag)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic        exp_wen;
        logic        exp_ren;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_ready;
        logic        exp_resp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sram [MEM];
    logic [7:0] arch [MEM];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                                input logic ew, input logic er, input logic [31:0] ea,
                                input logic [31:0] ed, input logic rdy, input logic rsp);
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.haddr = a; v.hsize = sz; v.hwdata = wd;
        v.exp_wen = ew; v.exp_ren = er; v.exp_addr = ea; v.exp_wdata = ed;
        v.exp_ready = rdy; v.exp_resp = rsp;
        return v;
    endfunction

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        int unsigned w;
        w = (a >> 2) * 4;
        if (w + 3 >= MEM) return 32'h0;
        return {sram[w+3], sram[w+2], sram[w+1], sram[w]};
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        int unsigned w;
        w = (a >> 2) * 4;
        return {arch[w+3], arch[w+2], arch[w+1], arch[w]};
    endfunction

    // Little-endian byte lanes: byte at address b travels on data[8*(b%4) +: 8].
    task automatic mem_write(input bit to_arch, input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] d);
        int unsigned b;
        for (int unsigned k = 0; k < (32'd1 << s); k++) begin
            b = a + k;
            if (b < MEM) begin
                if (to_arch) arch[b] = d[8*(b%4) +: 8];
                else         sram[b] = d[8*(b%4) +: 8];
            end
        end
    endtask

    task automatic set_sram_word(input logic [31:0] a, input logic [31:0] d);
        mem_write(1'b0, a, 2'd2, d);
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        ahb.HSEL = sel; ahb.HTRANS = trans; ahb.HWRITE = wr;
        ahb.HADDR = a; ahb.HSIZE = sz; ahb.HWDATA = wd;
        #4;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    // SRAM macro: strobes seen before the edge act on it; read data appears after.
    task automatic tick();
        logic        w, r;
        logic [31:0] a, d;
        logic [1:0]  s;
        w = wen; r = ren; a = addr; d = ram_wData; s = size;
        @(posedge clk);
        if (r) rData = sram_word(a);
        if (w) mem_write(1'b0, a, s, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t        vt[$];
        bit          pv_valid, pv_wr, cur_rd, cur_wr, cur_bad;
        logic [31:0] pv_addr, pv_wd, a, wd_now;
        logic [1:0]  pv_sz, tr;
        logic [2:0]  sz;
        int unsigned kind, err_cnt;

        rData = 32'h0;
        for (int unsigned b = 0; b < MEM; b++) sram[b] = 8'h00;

        // ---------------- reset state ----------------
        do_reset();
        idle();
        chk("rst flag", 32'(latched_flag), 32'd0);
        chk("rst wen", 32'(wen), 32'd0);
        chk("rst ren", 32'(ren), 32'd0);
        chk("rst addr", addr, 32'd0);
        chk("rst size", 32'(size), 32'd0);
        chk("rst hrdata", ahb.HRDATA, 32'd0);
        chk("rst ready", 32'(ahb.HREADYOUT), 32'd1);
        chk("rst resp", 32'(ahb.HRESP), 32'd0);
        tick();

        // ---------------- vector table ----------------
        vt.push_back(mk(1'b0, 2'b10, 1'b0, 32'h4, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 32'h4, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b00, 1'b1, 32'h8, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        for (int unsigned i = 0; i <= 8; i++) begin
            if (i < 8)
                vt.push_back(mk(1'b1, 2'b10, 1'b1, 32'(i), 3'd0, (i == 0) ? 32'h0 : 32'hA0 + i - 1,
                                (i != 0), 1'b0, 32'(i) - 1, 32'hA0 + i - 1, 1'b1, 1'b0));
            else
                vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'hA7,
                                1'b1, 1'b0, 32'd7, 32'hA7, 1'b1, 1'b0));
        end
        vt.push_back(mk(1'b1, 2'b10, 1'b1, 32'd24, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1));
        vt.push_back(mk(1'b1, 2'b11, 1'b0, 32'h100, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1));
        vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));

        foreach (vt[i]) begin
            drive(vt[i].sel, vt[i].trans, vt[i].wr, vt[i].haddr, vt[i].hsize, vt[i].hwdata);
            chk($sformatf("vec%0d wen", i), 32'(wen), 32'(vt[i].exp_wen));
            chk($sformatf("vec%0d ren", i), 32'(ren), 32'(vt[i].exp_ren));
            chk($sformatf("vec%0d ready", i), 32'(ahb.HREADYOUT), 32'(vt[i].exp_ready));
            chk($sformatf("vec%0d resp", i), 32'(ahb.HRESP), 32'(vt[i].exp_resp));
            if (vt[i].exp_wen || vt[i].exp_ren) chk($sformatf("vec%0d addr", i), addr, vt[i].exp_addr);
            if (vt[i].exp_wen) chk($sformatf("vec%0d wdata", i), ram_wData, vt[i].exp_wdata);
            tick();
        end

        // ---------------- read during write data phase ----------------
        do_reset();
        set_sram_word(32'd16, 32'hDEADBEEF);
        drive(1'b1, 2'b10, 1'b1, 32'd8, 3'd2, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 32'd16, 3'd2, 32'd9);
        chk("rdw wen", 32'(wen), 32'd0);
        chk("rdw ren", 32'(ren), 32'd1);
        chk("rdw addr", addr, 32'd16);
        tick();
        idle();
        chk("rdw hrdata", ahb.HRDATA, 32'hDEADBEEF);
        chk("rdw commit wen", 32'(wen), 32'd1);
        chk("rdw commit addr", addr, 32'd8);
        chk("rdw commit wdata", ram_wData, 32'd9);
        tick();
        idle();
        chk("rdw flag clear", 32'(latched_flag), 32'd0);
        chk("rdw no wen", 32'(wen), 32'd0);
        tick();
        chk("rdw sram word8", sram_word(32'd8), 32'd9);

        // ---------------- buffer held across an intervening read ----------------
        do_reset();
        set_sram_word(32'd0, 32'h11223344);
        set_sram_word(32'd4, 32'hBAD1BAD1);
        drive(1'b1, 2'b10, 1'b1, 32'h4, 3'd1, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 32'h2, 3'd1, 32'hDEAD1234);
        chk("ivr ren", 32'(ren), 32'd1);
        chk("ivr wen", 32'(wen), 32'd0);
        tick();
        drive(1'b1, 2'b11, 1'b0, 32'h4, 3'd0, 32'h0);
        chk("ivr flag", 32'(latched_flag), 32'd1);
        chk("ivr laddr", latched_addr, 32'h4);
        chk("ivr ldata", latched_data, 32'hDEAD1234);
        chk("ivr lsize", 32'(latched_size), 32'd1);
        chk("ivr size", 32'(size), 32'd0);
        chk("ivr hrdata0", ahb.HRDATA, 32'h11223344);
        tick();
        idle();
        chk("ivr hrdata fwd", ahb.HRDATA, 32'hBAD11234);
        chk("ivr commit wen", 32'(wen), 32'd1);
        chk("ivr commit addr", addr, 32'h4);
        chk("ivr commit wdata", ram_wData, 32'hDEAD1234);
        tick();
        idle();
        chk("ivr flag clear", 32'(latched_flag), 32'd0);
        tick();

        // ---------------- forwarding, lower and upper lanes ----------------
        do_reset();
        set_sram_word(32'd4, 32'hBAD1BAD1);
        drive(1'b1, 2'b10, 1'b1, 32'h4, 3'd1, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 32'h4, 3'd0, 32'hDEAD1234);
        tick();
        idle();
        chk("fwd flag", 32'(latched_flag), 32'd1);
        chk("fwd laddr", latched_addr, 32'h4);
        chk("fwd ldata", latched_data, 32'hDEAD1234);
        chk("fwd hrdata lo", 32'(ahb.HRDATA[15:0]), 32'h1234);
        chk("fwd hrdata hi", 32'(ahb.HRDATA[31:16]), 32'hBAD1);
        tick();
        drive(1'b1, 2'b10, 1'b1, 32'h7, 3'd0, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 32'h4, 3'd2, 32'hAB000000);
        tick();
        idle();
        chk("fwd byte3 hrdata", ahb.HRDATA, 32'hABD11234);
        tick();
        idle();
        tick();
        chk("fwd byte3 sram", sram_word(32'h4), 32'hABD11234);

        // ---------------- reset while the buffer holds a write ----------------
        drive(1'b1, 2'b10, 1'b1, 32'd8, 3'd2, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 32'd0, 3'd2, 32'h55);
        tick();
        rst = 1'b1;
        idle();
        chk("rmb flag before", 32'(latched_flag), 32'd1);
        chk("rmb wen in reset", 32'(wen), 32'd0);
        tick();
        rst = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("rmb flag%0d", i), 32'(latched_flag), 32'd0);
            chk($sformatf("rmb wen%0d", i), 32'(wen), 32'd0);
            tick();
        end
        chk("rmb sram word8", sram_word(32'd8), 32'd9);

        // ---------------- random traffic vs architectural memory ----------------
        do_reset();
        for (int unsigned b = 0; b < MEM; b++) arch[b] = sram[b];
        pv_valid = 1'b0; pv_wr = 1'b0; pv_addr = '0; pv_wd = '0; pv_sz = '0; err_cnt = 0;
        for (int unsigned c = 0; c < 2000; c++) begin
            cur_rd = 1'b0; cur_wr = 1'b0; cur_bad = 1'b0;
            wd_now = (pv_valid && pv_wr) ? pv_wd : $urandom();
            kind   = (err_cnt != 0) ? 7 : $urandom_range(0, 9);
            sz     = 3'($urandom_range(0, 2));
            a      = 32'($urandom_range(0, MEM - 1)) & ~((32'd1 << sz) - 32'd1);
            tr     = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
            case (kind)
                0, 1, 2, 3: begin drive(1'b1, tr, 1'b1, a, sz, wd_now); cur_wr = 1'b1; end
                4, 5, 6:    begin drive(1'b1, tr, 1'b0, a, sz, wd_now); cur_rd = 1'b1; end
                7:          drive(1'b1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz, wd_now);
                8:          drive(1'b0, tr, 1'($urandom_range(0, 1)), a, sz, wd_now);
                default: begin
                    a = 32'(MEM) + 32'($urandom_range(0, 1000));
                    drive(1'b1, tr, 1'($urandom_range(0, 1)), a, sz, wd_now);
                    cur_bad = 1'b1;
                end
            endcase
            if (pv_valid && !pv_wr) chk($sformatf("rnd%0d hrdata", c), ahb.HRDATA, arch_word(pv_addr));
            if (pv_valid && pv_wr) begin
                mem_write(1'b1, pv_addr, pv_sz, wd_now);
                if (!cur_rd) chk($sformatf("rnd%0d wr wen", c), 32'(wen), 32'd1);
            end
            chk($sformatf("rnd%0d ready", c), 32'(ahb.HREADYOUT), (err_cnt == 2) ? 32'd0 : 32'd1);
            chk($sformatf("rnd%0d resp", c), 32'(ahb.HRESP), (err_cnt != 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d ren", c), 32'(ren), 32'(cur_rd));
            if (cur_rd) begin
                chk($sformatf("rnd%0d raddr", c), addr, a);
                chk($sformatf("rnd%0d rwen", c), 32'(wen), 32'd0);
            end
            tick();
            pv_valid = cur_rd || cur_wr;
            pv_wr    = cur_wr;
            pv_addr  = a;
            pv_sz    = sz[1:0];
            pv_wd    = $urandom();
            err_cnt  = cur_bad ? 2 : ((err_cnt > 0) ? err_cnt - 1 : 0);
        end
        drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, (pv_valid && pv_wr) ? pv_wd : 32'h0);
        if (pv_valid && !pv_wr) chk("rnd last hrdata", ahb.HRDATA, arch_word(pv_addr));
        if (pv_valid && pv_wr) mem_write(1'b1, pv_addr, pv_sz, pv_wd);
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            idle();
            tick();
        end
        for (int unsigned w = 0; w < MEM; w += 4)
            chk($sformatf("final word%0d", w / 4), sram_word(32'(w)), arch_word(32'(w)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ahb_slave_core.md
# sram_ahb_slave_core

AHB-Lite slave front end for the on-chip SRAM. It converts pipelined AHB address/data phases into single-cycle SRAM read/write strobes and drives the SRAM address, size, write data and enables. A one-entry write buffer lets a read issue in the same cycle as a pending write data phase, and read-after-write hazards on that buffer are forwarded. It sits between the AHB interconnect and the SRAM macro, which has a 1-cycle synchronous read.

## Interface
- BASE_ADDRESS, 0, byte address of the first SRAM byte on AHB.
- NUM_BYTES, 24, SRAM size in bytes; decoded range is [BASE_ADDRESS, BASE_ADDRESS+NUM_BYTES).

- HCLK  in  1  clock; single clock domain, all state updates on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  AHB byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- addr  out  32  SRAM byte address (HADDR − BASE_ADDRESS).
- size  out  2  SRAM access size.
- ram_wData  out  32  SRAM write data.
- wen  out  1  SRAM write strobe.
- ren  out  1  SRAM read strobe.
- rData  in  32  SRAM read data, valid one cycle after ren.
- latched_addr  out  32  buffered write address, AHB byte address.
- latched_data  out  32  buffered write data.
- latched_size  out  2  buffered write size.
- latched_flag  out  1  buffer valid.

## Operation
- Active transfer: HSEL=1 and HTRANS[1]=1 and HADDR in range. IDLE, BUSY or unselected cycles issue nothing.
- Address-phase registers capture HADDR, HSIZE[1:0], HWRITE and active every cycle.
- Each cycle, pick exactly one SRAM action in this priority order:
  1. **Read address phase:** ren=1, addr=HADDR−BASE, size=HSIZE[1:0], driven combinationally in that same cycle. If a write data phase is also present, copy {registered addr, HWDATA, registered size} into the buffer and set latched_flag. Any older buffered entry must already have drained (see 2).
  2. **Write data phase, no read:**
     - Buffer empty: wen=1, addr=registered addr−BASE, size=registered size, ram_wData=HWDATA (combinational).
     - Buffer full: commit the buffer (wen=1, buffer fields), and load the current write into the buffer.
  3. **Neither, buffer full:** commit the buffer, then clear latched_flag.
- Read data phase: HRDATA=rData. If latched_flag=1 and latched_addr[31:2] equals the read word address, replace the bytes covered by latched_addr[1:0]/latched_size with latched_data's corresponding lanes (little-endian).
- Lane convention: ram_wData carries the full HWDATA word; the SRAM selects byte lanes from addr[1:0] and size.
- Out-of-range selected active transfer: no SRAM action; two-cycle ERROR response (HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1).
- Otherwise HREADYOUT=1 and HRESP=0 (zero wait states).

## Timing
- Reset (synchronous): all registers cleared, latched_flag=0, wen=ren=0, addr=size=0, HRDATA=0, HREADYOUT=1, HRESP=0. Reset mid-burst discards the buffered write.
- Write latency: address phase at edge N, wen high during cycle N+1, SRAM captures at edge N+2.
- Read latency: ren/addr driven in the address cycle; HRDATA valid during the following data cycle.
- Back-to-back writes sustain one write per cycle.
- A read interleaved with a write defers that write by at least one cycle.
- Consecutive reads keep the buffer pending; forwarding covers every such read.

## Test plan
- **Streaming writes:** NONSEQ writes HADDR 0..7, HWDATA incrementing, one per cycle. In each data cycle i: wen=1, addr=i, ram_wData=HWDATA.
- **Read during write data phase:** write to 8 with data 9, then read at 16. In the read address cycle: wen=0, ren=1, addr=16. Next cycle: HRDATA=rData (0xDEADBEEF), wen=1, addr=8, ram_wData=9, latched_flag cleared.
- **Buffer with intervening read:** write 0x4 size 1 with data 0xDEAD1234, then read 0x2 size 1, then read 0x4 size 0. In the third cycle: latched_flag=1, latched_addr=4, latched_data=0xDEAD1234, latched_size=01, size=0.
- **Forwarding:** write 0x4 size 1 with data 0xDEAD1234, immediately read 0x4 size 0, with rData=0xBAD1BAD1. Buffer fields as above; HRDATA lower half=0x1234, upper half=0xBAD1.
- **Out of range:** access to HADDR=24. No wen/ren; two-cycle ERROR response.
- **Reset mid-buffer:** assert HRESET while latched_flag=1. Flag cleared; no wen after release.
